// File: rtl/nn_param_writer_pkg.sv
// nn_param_writer_pkg
// Shared definitions for the MLP parameter loader: the parameter word format,
// the network dimensions, the store-select encodings, the total word count,
// the loader state encodings and a sign-extension helper used by the checksum.
package nn_param_writer_pkg;

    // Parameter word: W-bit two's-complement fixed point. The binary-point
    // position belongs to the shared datapath format; the loader never
    // interprets it and passes words through unchanged.
    localparam int W     = 9;
    localparam int IDX_W = 7;   // clog2(max(N_IN, N_HID, N_OUT))

    localparam int N_IN  = 7;
    localparam int N_HID = 128;
    localparam int N_OUT = 3;

    localparam int N_WH1 = N_IN * N_HID;
    localparam int N_BH1 = N_HID;
    localparam int N_WO  = N_HID * N_OUT;
    localparam int N_BO  = N_OUT;
    localparam int TOTAL_WORDS = N_WH1 + N_BH1 + N_WO + N_BO;   // 1411

    typedef logic signed [W-1:0] param_word_t;

    localparam logic [1:0] SEL_WH1 = 2'd0;
    localparam logic [1:0] SEL_BH1 = 2'd1;
    localparam logic [1:0] SEL_WO  = 2'd2;
    localparam logic [1:0] SEL_BO  = 2'd3;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LD_WH1 = 3'd1;
    localparam logic [2:0] ST_LD_BH1 = 3'd2;
    localparam logic [2:0] ST_LD_WO  = 3'd3;
    localparam logic [2:0] ST_LD_BO  = 3'd4;
    localparam logic [2:0] ST_DONE   = 3'd5;

    function automatic logic [15:0] sext16(input logic [W-1:0] w);
        return {{(16-W){w[W-1]}}, w};
    endfunction

endpackage

// File: rtl/nn_param_writer_index_counter.sv
// nn_param_index_counter
// Row-major (column fastest) index counter for one parameter region.
// Ports:
//   clk, rst              clock, asynchronous active-low reset
//   load_i                zero the indices and latch new last-row/last-col limits
//   row_last_i/col_last_i last valid row/column index of the new region
//   step_i                advance by one element
//   row_o, col_o          current element position
//   last_col_o            current column is the last of its row
//   last_elem_o           current element is the last of the region
module nn_param_index_counter
    import nn_param_writer_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [IDX_W-1:0] row_last_i,
    input  logic [IDX_W-1:0] col_last_i,
    input  logic             step_i,
    output logic [IDX_W-1:0] row_o,
    output logic [IDX_W-1:0] col_o,
    output logic             last_col_o,
    output logic             last_elem_o
);

    logic [IDX_W-1:0] row_q, col_q;
    logic [IDX_W-1:0] row_lim_q, col_lim_q;
    logic             last_col, last_elem;

    assign last_col  = (col_q == col_lim_q);
    assign last_elem = last_col && (row_q == row_lim_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_q     <= '0;
            col_q     <= '0;
            row_lim_q <= '0;
            col_lim_q <= '0;
        end else if (load_i) begin
            row_q     <= '0;
            col_q     <= '0;
            row_lim_q <= row_last_i;
            col_lim_q <= col_last_i;
        end else if (step_i) begin
            if (last_col) begin
                col_q <= '0;
                row_q <= last_elem ? '0 : row_q + 1'b1;
            end else begin
                col_q <= col_q + 1'b1;
            end
        end
    end

    assign row_o       = row_q;
    assign col_o       = col_q;
    assign last_col_o  = last_col;
    assign last_elem_o = last_elem;

endmodule

// File: rtl/nn_param_writer.sv
// nn_param_writer
// Converts a valid/ready stream of parameter words into indexed write strobes
// for the four MLP parameter stores, in the order hidden weights, hidden
// biases, output weights, output biases, and keeps a running 16-bit checksum.
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   start               begin a load (honoured only in IDLE or DONE)
//   in_data/in_valid    incoming parameter word
//   in_ready            high in every load state
//   wr_en               one-cycle strobe per accepted word, one cycle later
//   wr_sel/row/col/data store select, position and word of the write
//   busy, done          load in progress / full set written
//   checksum            modulo-2^16 sum of sign-extended accepted words
//
// state     | meaning
// ----------+----------------------------------------------
// IDLE      | waiting for start, nothing accepted
// LD_WH1    | hidden weights, N_IN rows x N_HID cols
// LD_BH1    | hidden biases, N_HID cols
// LD_WO     | output weights, N_HID rows x N_OUT cols
// LD_BO     | output biases, N_OUT cols
// DONE      | full set written, done held until start
module nn_param_writer
    import nn_param_writer_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [W-1:0]     in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             wr_en,
    output logic [1:0]       wr_sel,
    output logic [IDX_W-1:0] wr_row,
    output logic [IDX_W-1:0] wr_col,
    output logic [W-1:0]     wr_data,
    output logic             busy,
    output logic             done,
    output logic [15:0]      checksum
);

    logic [2:0]       state_q, state_d;
    logic             wr_en_q;
    logic [1:0]       wr_sel_q;
    logic [IDX_W-1:0] wr_row_q, wr_col_q;
    logic [W-1:0]     wr_data_q;
    logic             done_q;
    logic [15:0]      checksum_q;

    logic             loading, accept, region_end, start_load;
    logic             cnt_load;
    logic [IDX_W-1:0] lim_row, lim_col;
    logic [IDX_W-1:0] cnt_row, cnt_col;
    logic             cnt_last_col, cnt_last_elem;
    logic [1:0]       cur_sel;

    assign loading    = (state_q == ST_LD_WH1) || (state_q == ST_LD_BH1) ||
                        (state_q == ST_LD_WO)  || (state_q == ST_LD_BO);
    assign accept     = in_valid && loading;
    // The last element of a region is necessarily in its last column.
    assign region_end = accept && cnt_last_col && cnt_last_elem;
    assign start_load = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

    nn_param_index_counter u_idx (
        .clk         (clk),
        .rst         (rst),
        .load_i      (cnt_load),
        .row_last_i  (lim_row),
        .col_last_i  (lim_col),
        .step_i      (accept),
        .row_o       (cnt_row),
        .col_o       (cnt_col),
        .last_col_o  (cnt_last_col),
        .last_elem_o (cnt_last_elem)
    );

    // Next state plus the limits of the region being entered; the counter
    // reloads on the same edge that accepts a region's last word, so the
    // next region's first word can be taken on the following cycle.
    always_comb begin
        state_d  = state_q;
        cnt_load = 1'b0;
        lim_row  = IDX_W'(N_IN - 1);
        lim_col  = IDX_W'(N_HID - 1);
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_load) begin
                    state_d  = ST_LD_WH1;
                    cnt_load = 1'b1;
                end
            end
            ST_LD_WH1: begin
                if (region_end) begin
                    state_d  = ST_LD_BH1;
                    cnt_load = 1'b1;
                    lim_row  = '0;
                    lim_col  = IDX_W'(N_HID - 1);
                end
            end
            ST_LD_BH1: begin
                if (region_end) begin
                    state_d  = ST_LD_WO;
                    cnt_load = 1'b1;
                    lim_row  = IDX_W'(N_HID - 1);
                    lim_col  = IDX_W'(N_OUT - 1);
                end
            end
            ST_LD_WO: begin
                if (region_end) begin
                    state_d  = ST_LD_BO;
                    cnt_load = 1'b1;
                    lim_row  = '0;
                    lim_col  = IDX_W'(N_OUT - 1);
                end
            end
            ST_LD_BO: begin
                if (region_end) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cur_sel = SEL_WH1;
        case (state_q)
            ST_LD_BH1: cur_sel = SEL_BH1;
            ST_LD_WO:  cur_sel = SEL_WO;
            ST_LD_BO:  cur_sel = SEL_BO;
            default:   cur_sel = SEL_WH1;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            wr_en_q    <= 1'b0;
            wr_sel_q   <= '0;
            wr_row_q   <= '0;
            wr_col_q   <= '0;
            wr_data_q  <= '0;
            done_q     <= 1'b0;
            checksum_q <= '0;
        end else begin
            state_q <= state_d;
            wr_en_q <= accept;
            if (accept) begin
                wr_sel_q   <= cur_sel;
                wr_row_q   <= cnt_row;
                wr_col_q   <= cnt_col;
                wr_data_q  <= in_data;
                checksum_q <= checksum_q + sext16(in_data);
            end
            // start_load and accept are mutually exclusive by state.
            if (start_load) begin
                checksum_q <= '0;
                done_q     <= 1'b0;
            end else if (region_end && (state_q == ST_LD_BO)) begin
                done_q <= 1'b1;
            end
        end
    end

    assign in_ready = loading;
    assign busy     = loading;
    assign wr_en    = wr_en_q;
    assign wr_sel   = wr_sel_q;
    assign wr_row   = wr_row_q;
    assign wr_col   = wr_col_q;
    assign wr_data  = wr_data_q;
    assign done     = done_q;
    assign checksum = checksum_q;

endmodule

// File: tb/tb_nn_param_writer.sv
module tb_nn_param_writer;
    import nn_param_writer_pkg::*;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic [W-1:0]     in_data = '0;
    logic             in_valid = 1'b0;
    logic             in_ready, wr_en, busy, done;
    logic [1:0]       wr_sel;
    logic [IDX_W-1:0] wr_row, wr_col;
    logic [W-1:0]     wr_data;
    logic [15:0]      checksum;

    nn_param_writer dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .wr_en    (wr_en),
        .wr_sel   (wr_sel),
        .wr_row   (wr_row),
        .wr_col   (wr_col),
        .wr_data  (wr_data),
        .busy     (busy),
        .done     (done),
        .checksum (checksum)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Known write positions for selected word numbers of a load.
    typedef struct {
        int k;
        int sel;
        int row;
        int col;
    } vec_t;
    vec_t tbl[12];

    // Behavioural reference: what the outputs must show after the next edge.
    bit   m_loading, m_done;
    int   m_count;
    bit   e_wr_en;
    int   e_sel, e_row, e_col, e_k, e_sum;
    logic [W-1:0] e_data;
    int   pulses;
    bit   final_en = 1'b0;
    int   final_sum = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Word number -> (store, row, col) straight from the region sizes.
    function automatic void pos_of(input int k, output int sel, output int row, output int col);
        if (k < N_WH1) begin
            sel = 0; row = k / N_HID; col = k % N_HID;
        end else if (k < N_WH1 + N_BH1) begin
            sel = 1; row = 0; col = k - N_WH1;
        end else if (k < N_WH1 + N_BH1 + N_WO) begin
            sel = 2; row = (k - N_WH1 - N_BH1) / N_OUT; col = (k - N_WH1 - N_BH1) % N_OUT;
        end else begin
            sel = 3; row = 0; col = k - N_WH1 - N_BH1 - N_WO;
        end
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            chk("reset_outputs",
                64'({in_ready, busy, done, wr_en, wr_sel, wr_row, wr_col, wr_data, checksum}), 64'd0);
            m_loading = 0; m_done = 0; m_count = 0;
            e_wr_en = 0; e_sel = 0; e_row = 0; e_col = 0; e_k = 0; e_sum = 0; e_data = '0;
            pulses = 0;
        end else begin
            chk("in_ready", 64'(in_ready), 64'(m_loading));
            chk("busy", 64'(busy), 64'(m_loading));
            chk("done", 64'(done), 64'(m_done));
            chk("wr_en", 64'(wr_en), 64'(e_wr_en));
            chk("wr_sel", 64'(wr_sel), 64'(e_sel));
            chk("wr_row", 64'(wr_row), 64'(e_row));
            chk("wr_col", 64'(wr_col), 64'(e_col));
            chk("wr_data", 64'(wr_data), 64'(e_data));
            chk("checksum", 64'(checksum), 64'(e_sum));
            if (wr_en) pulses++;
            if (e_wr_en) begin
                for (int i = 0; i < 12; i++) begin
                    if (tbl[i].k == e_k) begin
                        chk("tbl_sel", 64'(wr_sel), 64'(tbl[i].sel));
                        chk("tbl_row", 64'(wr_row), 64'(tbl[i].row));
                        chk("tbl_col", 64'(wr_col), 64'(tbl[i].col));
                    end
                end
                if (e_k == TOTAL_WORDS - 1) begin
                    chk("write_count", 64'(pulses), 64'(TOTAL_WORDS));
                    chk("done_with_last", 64'(done), 64'd1);
                    if (final_en) chk("final_checksum", 64'(checksum), 64'(final_sum));
                end
            end
            // Advance the model by the inputs that the next edge will see.
            e_wr_en = 0;
            if (m_loading && in_valid) begin
                e_wr_en = 1;
                pos_of(m_count, e_sel, e_row, e_col);
                e_data = in_data;
                e_k = m_count;
                e_sum = ((e_sum + int'($signed(in_data))) % 65536 + 65536) % 65536;
                m_count++;
                if (m_count == TOTAL_WORDS) begin
                    m_loading = 0;
                    m_done = 1;
                end
            end else if (!m_loading && start) begin
                m_loading = 1; m_count = 0; e_sum = 0; m_done = 0; pulses = 0;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] word_of(input int mode, input int k);
        case (mode)
            0:       return 9'h001;
            1:       return 9'h1FF;
            2:       return W'(k % 512);
            default: return W'($urandom);
        endcase
    endfunction

    task automatic do_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    // Offer n words; gap_pct percent of cycles carry no word. With
    // pulse_start, start is raised together with words 10 and 900.
    task automatic load(input int mode, input int gap_pct, input bit pulse_start, input int n);
        int k = 0;
        while (k < n) begin
            if ($urandom_range(99) >= gap_pct) begin
                in_valid = 1'b1;
                in_data  = word_of(mode, k);
                start    = pulse_start && (k == 10 || k == 900);
                k++;
            end else begin
                in_valid = 1'b0;
                in_data  = W'($urandom);
                start    = 1'b0;
            end
            cyc();
        end
        in_valid = 1'b0;
        start    = 1'b0;
    endtask

    initial begin
        tbl[0]  = '{0,    0, 0,   0};
        tbl[1]  = '{127,  0, 0,   127};
        tbl[2]  = '{128,  0, 1,   0};
        tbl[3]  = '{895,  0, 6,   127};
        tbl[4]  = '{896,  1, 0,   0};
        tbl[5]  = '{1023, 1, 0,   127};
        tbl[6]  = '{1024, 2, 0,   0};
        tbl[7]  = '{1027, 2, 1,   0};
        tbl[8]  = '{1407, 2, 127, 2};
        tbl[9]  = '{1408, 3, 0,   0};
        tbl[10] = '{1409, 3, 0,   1};
        tbl[11] = '{1410, 3, 0,   2};

        repeat (3) cyc();
        rst = 1'b1;
        cyc();

        // Words offered in IDLE are ignored.
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_data = W'($urandom);
            cyc();
        end
        in_valid = 1'b0;

        // Full-rate load of +1 words.
        final_en = 1'b1; final_sum = 16'h0583;
        do_start();
        load(0, 0, 1'b0, TOTAL_WORDS);
        repeat (4) cyc();

        // -1 words with random gaps.
        final_sum = 16'hFA7D;
        do_start();
        load(1, 40, 1'b0, TOTAL_WORDS);
        repeat (4) cyc();

        // Start pulses inside a load must be ignored.
        final_en = 1'b0;
        do_start();
        load(3, 30, 1'b1, TOTAL_WORDS);
        repeat (4) cyc();

        // Abort after 500 words with a reset between clock edges.
        do_start();
        load(3, 0, 1'b0, 500);
        #1 rst = 1'b0;
        cyc();
        cyc();
        rst = 1'b1;
        in_valid = 1'b1;
        in_data  = W'($urandom);
        cyc();
        in_valid = 1'b0;

        // Reload from index 0 with index-valued words.
        do_start();
        load(2, 20, 1'b0, TOTAL_WORDS);

        // DONE ignores offered words, then a restart clears and reloads.
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_data = W'($urandom);
            cyc();
        end
        do_start();
        load(3, 10, 1'b0, TOTAL_WORDS);
        repeat (4) cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
